serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one bit per clock, WIDTH+2 cycle operation period.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_sum;
   logic             r_c;
   logic             r_carry;
   logic             r_done;
   logic [CW-1:0]    r_cnt;
   logic             w_start_acc;
   logic             w_last;
   logic             w_p;
   logic             w_s;
   logic             w_c_next;

   assign w_start_acc = (r_state == IDLE) && start;
   assign w_last      = (r_cnt == CW'(WIDTH - 1));

   // Two half-adder cells: propagate/sum, then generate ORed with propagated carry.
   assign w_p      = r_a[0] ^ r_b[0];
   assign w_s      = w_p ^ r_c;
   assign w_c_next = (r_a[0] & r_b[0]) | (w_p & r_c);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = RUN;
         RUN:     if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == RUN);
      done = r_done;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_c     <= 1'b0;
         r_carry <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_done <= (r_state == RUN) && w_last;
         if (w_start_acc) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= 1'b0;
            r_cnt <= '0;
         end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_c   <= w_c_next;
            r_res <= {w_s, r_res[WIDTH-1:1]};
            r_cnt <= r_cnt + CW'(1);
            // Result registers only change on the final bit, so they hold across the next run.
            if (w_last) begin
               r_sum   <= {w_s, r_res[WIDTH-1:1]};
               r_carry <= w_c_next;
            end
         end
      end
   end

   assign sum   = r_sum;
   assign carry = r_carry;

`ifdef SERIAL_ADDER_OVF_EN
   logic r_ovf;

   // On the last bit r_c is the carry into the MSB and w_c_next the carry out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if ((r_state == RUN) && w_last) begin
         r_ovf <= r_c ^ w_c_next;
      end
   end

   assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a WIDTH=8 instance for directed cases and a WIDTH=2 instance for an exhaustive sweep.
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start8, busy8, done8, carry8;
   logic [7:0] a8, b8, sum8;
   logic       start2, busy2, done2, carry2;
   logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf8, ovf2;
`endif

   typedef struct packed {
      int sum;
      int carry;
      int ovf;
   } exp_t;

   exp_t q8[$];
   exp_t q2[$];
   exp_t e8, e2;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   dcnt8 = 0;
   int   dcnt2 = 0;
   int   last_d2 = -1;
   int   prev_sum8 = 0;
   int   prev_carry8 = 0;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .carry (carry8)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf8)
`endif
   );

   serial_adder #(.WIDTH(2)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start2),
      .a     (a2),
      .b     (b2),
      .busy  (busy2),
      .done  (done2),
      .sum   (sum2),
      .carry (carry2)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf2)
`endif
   );

   task automatic check_val(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference: plain integer addition, overflow from operand/result sign bits.
   function automatic exp_t model(input int w, input int x, input int y);
      exp_t r;
      int   s;
      int   mask;
      s       = x + y;
      mask    = (1 << w) - 1;
      r.sum   = s & mask;
      r.carry = (s >> w) & 1;
      r.ovf   = ((((x >> (w - 1)) & 1) == ((y >> (w - 1)) & 1)) &&
                 (((r.sum >> (w - 1)) & 1) != ((x >> (w - 1)) & 1))) ? 1 : 0;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done8) begin
         dcnt8++;
         if (q8.size() == 0) begin
            check_val("w8_unexpected_done", 1, 0);
         end else begin
            e8 = q8.pop_front();
            $display("txn w8 sum=%0d carry=%0d exp_sum=%0d exp_carry=%0d", sum8, carry8, e8.sum, e8.carry);
            check_val("w8_sum", int'(sum8), e8.sum);
            check_val("w8_carry", int'(carry8), e8.carry);
`ifdef SERIAL_ADDER_OVF_EN
            check_val("w8_ovf", int'(ovf8), e8.ovf);
`endif
         end
         check_val("w8_busy_with_done", int'(busy8), 0);
      end
      if (done2) begin
         dcnt2++;
         if (q2.size() == 0) begin
            check_val("w2_unexpected_done", 1, 0);
         end else begin
            e2 = q2.pop_front();
            $display("txn w2 sum=%0d carry=%0d exp_sum=%0d exp_carry=%0d", sum2, carry2, e2.sum, e2.carry);
            check_val("w2_sum", int'(sum2), e2.sum);
            check_val("w2_carry", int'(carry2), e2.carry);
`ifdef SERIAL_ADDER_OVF_EN
            check_val("w2_ovf", int'(ovf2), e2.ovf);
`endif
         end
         if (last_d2 >= 0) check_val("w2_period", cyc - last_d2, 4);
         last_d2 = cyc;
      end
   end

   // One WIDTH=8 operation: start on edge 0, expect 8 busy cycles then a single-cycle done.
   task automatic op8(input int x, input int y, input string tag);
      exp_t e;
      int   nb;
      int   k;
      e      = model(8, x, y);
      a8     = 8'(x);
      b8     = 8'(y);
      start8 = 1'b1;
      q8.push_back(e);
      step();
      start8 = 1'b0;
      check_val({tag, "_hold_sum"}, int'(sum8), prev_sum8);
      check_val({tag, "_hold_carry"}, int'(carry8), prev_carry8);
      nb = 0;
      k  = 0;
      while (!done8 && k < 40) begin
         if (busy8) nb++;
         step();
         k++;
      end
      check_val({tag, "_done_seen"}, int'(done8), 1);
      check_val({tag, "_busy_cycles"}, nb, 8);
      step();
      check_val({tag, "_done_pulse_end"}, int'(done8), 0);
      prev_sum8   = e.sum;
      prev_carry8 = e.carry;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      exp_t e;
      rst_n  = 1'b0;
      start8 = 1'b0;
      a8     = '0;
      b8     = '0;
      start2 = 1'b0;
      a2     = '0;
      b2     = '0;
      #3;
      check_val("rst_busy", int'(busy8), 0);
      check_val("rst_done", int'(done8), 0);
      check_val("rst_sum", int'(sum8), 0);
      check_val("rst_carry", int'(carry8), 0);
`ifdef SERIAL_ADDER_OVF_EN
      check_val("rst_ovf", int'(ovf8), 0);
`endif
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      op8(3, 5, "add_3_5");
      op8(255, 1, "add_255_1");
      op8(127, 1, "add_127_1");
      op8(128, 128, "add_128_128");
      for (int i = 0; i < 4; i++) begin
         op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), "add_rand");
      end

      // A second start inside RUN must be ignored: result stays 1+2.
      d0 = dcnt8;
      e  = model(8, 1, 2);
      a8 = 8'd1;
      b8 = 8'd2;
      start8 = 1'b1;
      q8.push_back(e);
      step();
      start8 = 1'b0;
      step();
      step();
      a8 = 8'd9;
      b8 = 8'd9;
      start8 = 1'b1;
      step();
      start8 = 1'b0;
      repeat (15) step();
      check_val("repulse_done_count", dcnt8 - d0, 1);
      check_val("repulse_sum_held", int'(sum8), 3);
      prev_sum8   = 3;
      prev_carry8 = 0;

      // Reset at edge 4 of RUN aborts the operation and clears outputs at once.
      d0 = dcnt8;
      a8 = 8'd10;
      b8 = 8'd20;
      start8 = 1'b1;
      q8.push_back(model(8, 10, 20));
      step();
      start8 = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      check_val("abort_busy", int'(busy8), 0);
      check_val("abort_done", int'(done8), 0);
      check_val("abort_sum", int'(sum8), 0);
      check_val("abort_carry", int'(carry8), 0);
      q8.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (14) step();
      check_val("abort_no_done", dcnt8 - d0, 0);
      prev_sum8   = 0;
      prev_carry8 = 0;
      op8(100, 50, "after_abort");

      // Exhaustive WIDTH=2 sweep with start held high: one accept every 4 cycles.
      d0 = dcnt2;
      start2 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a2 = 2'(i >> 2);
         b2 = 2'(i & 3);
         q2.push_back(model(2, i >> 2, i & 3));
         step();
         check_val("w2_accept", int'(busy2), 1);
         repeat (3) step();
      end
      start2 = 1'b0;
      repeat (6) step();
      check_val("w2_done_count", dcnt2 - d0, 16);
      check_val("w2_queue_empty", q2.size(), 0);
      check_val("w8_queue_empty", q8.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
